// File: rtl/tl_ul_arbiter_if.sv
// Bus bundle for the TL-UL arbiter: N client ports on one side, one manager port on the other.
// The slave modport is the arbiter's view; the master modport is the clients and manager.
interface tl_ul_arbiter_if #(
  parameter int N_REQ        = 2,
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 32,
  parameter int SOURCE_WIDTH = 4,
  parameter int SINK_WIDTH   = 4,
  parameter int SIZE_WIDTH   = 4
);
  localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int M_SRC_W = SOURCE_WIDTH + IDX_W;
  localparam int A_W_C   = 6 + SIZE_WIDTH + SOURCE_WIDTH + ADDR_WIDTH + DATA_WIDTH/8 + DATA_WIDTH + 1;
  localparam int A_W_M   = 6 + SIZE_WIDTH + M_SRC_W + ADDR_WIDTH + DATA_WIDTH/8 + DATA_WIDTH + 1;
  localparam int D_W_C   = 5 + SIZE_WIDTH + SOURCE_WIDTH + SINK_WIDTH + 1 + DATA_WIDTH + 1;
  localparam int D_W_M   = 5 + SIZE_WIDTH + M_SRC_W + SINK_WIDTH + 1 + DATA_WIDTH + 1;

  logic [N_REQ-1:0]       c_a_valid;
  logic [N_REQ*A_W_C-1:0] c_a_bits;
  logic [N_REQ-1:0]       c_a_ready;
  logic [N_REQ-1:0]       c_d_valid;
  logic [D_W_C-1:0]       c_d_bits;
  logic [N_REQ-1:0]       c_d_ready;
  logic                   m_a_valid;
  logic [A_W_M-1:0]       m_a_bits;
  logic                   m_a_ready;
  logic                   m_d_valid;
  logic [D_W_M-1:0]       m_d_bits;
  logic                   m_d_ready;

  modport slave (
    input  c_a_valid, c_a_bits, c_d_ready, m_a_ready, m_d_valid, m_d_bits,
    output c_a_ready, c_d_valid, c_d_bits, m_a_valid, m_a_bits, m_d_ready
  );

  modport master (
    output c_a_valid, c_a_bits, c_d_ready, m_a_ready, m_d_valid, m_d_bits,
    input  c_a_ready, c_d_valid, c_d_bits, m_a_valid, m_a_bits, m_d_ready
  );
endinterface

// File: rtl/tl_ul_arbiter.sv
// N-client to 1-manager TL-UL arbiter: round-robin A channel with stall lock,
// D routed back by source prefix, per-client outstanding throttling.
//
// state     | meaning
// ST_IDLE   | grant chosen combinationally from rr_ptr each cycle
// ST_LOCKED | manager stalled a beat; grant frozen in g_q until accepted
module tl_ul_arbiter #(
  parameter int N_REQ        = 2,
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 32,
  parameter int SOURCE_WIDTH = 4,
  parameter int SINK_WIDTH   = 4,
  parameter int SIZE_WIDTH   = 4,
  parameter int MAX_OUTST    = 4
) (
  input  logic              clk,
  input  logic              reset,
  tl_ul_arbiter_if.slave    bus,
  output logic              err_bad_source
);
  localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int M_SRC_W = SOURCE_WIDTH + IDX_W;
  localparam int CNT_W   = $clog2(MAX_OUTST + 1);
  localparam int A_LO_W  = ADDR_WIDTH + DATA_WIDTH/8 + DATA_WIDTH + 1;
  localparam int A_HI_W  = 6 + SIZE_WIDTH;
  localparam int A_W_C   = A_HI_W + SOURCE_WIDTH + A_LO_W;
  localparam int D_LO_W  = SINK_WIDTH + DATA_WIDTH + 2;
  localparam int D_HI_W  = 5 + SIZE_WIDTH;
  localparam int D_W_M   = D_HI_W + M_SRC_W + D_LO_W;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);
  localparam logic [IDX_W:0]   N_REQ_L = (IDX_W+1)'(N_REQ);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] g_q;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] d_idx;
  logic [CNT_W-1:0] outst [N_REQ];
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] inc;
  logic [N_REQ-1:0] dec;
  logic             any_elig;
  logic             a_hs;
  logic             d_hs;
  logic             d_bad;
  logic             d_in_range;
  logic             d_cnt_zero;
  logic [A_W_C-1:0] a_sel;

  // Round-robin pick: first eligible client at or after rr_ptr; lock overrides.
  always_comb begin
    elig     = '0;
    any_elig = 1'b0;
    sel      = rr_ptr;
    for (int i = 0; i < N_REQ; i++)
      elig[i] = bus.c_a_valid[i] && (outst[i] < CNT_MAX);
    for (int k = 0; k < N_REQ; k++) begin
      automatic int j = int'(rr_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!any_elig && elig[j]) begin
        sel      = IDX_W'(j);
        any_elig = 1'b1;
      end
    end
    if (state == ST_LOCKED) sel = g_q;
  end

  always_comb begin
    a_sel = '0;
    for (int i = 0; i < N_REQ; i++)
      if (sel == IDX_W'(i)) a_sel = bus.c_a_bits[i*A_W_C +: A_W_C];
  end

  assign bus.m_a_valid = !reset && (state == ST_LOCKED || any_elig);
  assign bus.m_a_bits  = {a_sel[A_W_C-1 -: A_HI_W], sel,
                          a_sel[A_LO_W +: SOURCE_WIDTH], a_sel[A_LO_W-1:0]};
  assign a_hs          = bus.m_a_valid && bus.m_a_ready;

  assign d_idx      = bus.m_d_bits[D_LO_W + M_SRC_W - 1 -: IDX_W];
  assign d_in_range = {1'b0, d_idx} < N_REQ_L;

  always_comb begin
    d_cnt_zero = 1'b1;
    for (int i = 0; i < N_REQ; i++)
      if (d_idx == IDX_W'(i)) d_cnt_zero = (outst[i] == '0);
  end

  // A response nobody is waiting for is swallowed so the manager never hangs.
  assign d_bad = bus.m_d_valid && (!d_in_range || d_cnt_zero);

  always_comb begin
    bus.c_d_valid = '0;
    bus.m_d_ready = 1'b0;
    if (!reset) begin
      if (d_bad) begin
        bus.m_d_ready = 1'b1;
      end else begin
        for (int i = 0; i < N_REQ; i++)
          if (d_idx == IDX_W'(i)) begin
            bus.c_d_valid[i] = bus.m_d_valid;
            bus.m_d_ready    = bus.c_d_ready[i];
          end
      end
    end
  end

  assign d_hs         = bus.m_d_valid && bus.m_d_ready && !d_bad;
  assign bus.c_d_bits = {bus.m_d_bits[D_W_M-1 -: D_HI_W],
                         bus.m_d_bits[D_LO_W +: SOURCE_WIDTH], bus.m_d_bits[D_LO_W-1:0]};

  always_comb begin
    bus.c_a_ready = '0;
    inc           = '0;
    dec           = '0;
    for (int i = 0; i < N_REQ; i++) begin
      bus.c_a_ready[i] = a_hs && (sel == IDX_W'(i));
      inc[i]           = a_hs && (sel == IDX_W'(i));
      dec[i]           = d_hs && (d_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      rr_ptr         <= '0;
      g_q            <= '0;
      err_bad_source <= 1'b0;
      for (int i = 0; i < N_REQ; i++) outst[i] <= '0;
    end else begin
      err_bad_source <= d_bad;
      case (state)
        ST_IDLE:
          if (bus.m_a_valid && !bus.m_a_ready) begin
            state <= ST_LOCKED;
            g_q   <= sel;
          end
        ST_LOCKED:
          if (bus.m_a_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      if (a_hs) rr_ptr <= (sel == IDX_W'(N_REQ-1)) ? '0 : sel + 1'b1;
      for (int i = 0; i < N_REQ; i++) begin
        if (inc[i] && !dec[i])
          outst[i] <= outst[i] + 1'b1;
        else if (dec[i] && !inc[i] && outst[i] != '0)
          outst[i] <= outst[i] - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_tl_ul_arbiter.sv
// Directed bench for tl_ul_arbiter with three clients (2-bit prefix, 6-bit manager source).
module tb_tl_ul_arbiter;
  localparam int A_W_C = 119;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic err_bad_source;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  tl_ul_arbiter_if #(.N_REQ(3)) bus ();

  tl_ul_arbiter #(.N_REQ(3), .MAX_OUTST(4)) dut (
    .clk(clk), .reset(reset), .bus(bus), .err_bad_source(err_bad_source)
  );

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [118:0] mk_ca(input logic [2:0] op, input logic [3:0] src, input logic [31:0] addr);
    return {op, 3'd0, 4'd3, src, addr, 8'hff, addr, ~addr, 1'b0};
  endfunction

  function automatic logic [120:0] mk_ma(input logic [2:0] op, input logic [5:0] src, input logic [31:0] addr);
    return {op, 3'd0, 4'd3, src, addr, 8'hff, addr, ~addr, 1'b0};
  endfunction

  function automatic logic [84:0] mk_md(input logic [2:0] op, input logic [5:0] src, input logic [63:0] data);
    return {op, 2'd0, 4'd3, src, 4'h9, 1'b0, data, 1'b0};
  endfunction

  function automatic logic [82:0] mk_cd(input logic [2:0] op, input logic [3:0] src, input logic [63:0] data);
    return {op, 2'd0, 4'd3, src, 4'h9, 1'b0, data, 1'b0};
  endfunction

  task automatic set_ca(input int i, input logic [118:0] v);
    bus.c_a_bits[i*A_W_C +: A_W_C] = v;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic send_d(input logic [5:0] src, input logic [2:0] exp_cdv);
    bus.m_d_valid = 1'b1;
    bus.m_d_bits  = mk_md(3'd0, src, 64'd0);
    settle();
    check_val("drain_c_d_valid", bus.c_d_valid, exp_cdv);
    tick();
    bus.m_d_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.c_a_valid = '0;
    bus.c_a_bits  = '0;
    bus.c_d_ready = '0;
    bus.m_a_ready = 1'b0;
    bus.m_d_valid = 1'b0;
    bus.m_d_bits  = '0;

    // Reset: outputs quiet even with stimulus present
    tick();
    bus.c_a_valid = 3'b001;
    set_ca(0, mk_ca(3'd4, 4'h3, 32'h1000));
    bus.m_a_ready = 1'b1;
    bus.m_d_valid = 1'b1;
    bus.m_d_bits  = mk_md(3'd1, 6'h35, 64'd0);
    settle();
    check_val("rst_m_a_valid", bus.m_a_valid, 1'b0);
    check_val("rst_c_a_ready", bus.c_a_ready, 3'b000);
    check_val("rst_m_d_ready", bus.m_d_ready, 1'b0);
    check_val("rst_err", err_bad_source, 1'b0);
    tick();
    bus.m_d_valid = 1'b0;
    reset = 1'b0;

    // Basic grant and D route
    settle();
    check_val("basic_m_a_valid", bus.m_a_valid, 1'b1);
    check_val("basic_m_a_bits", bus.m_a_bits, mk_ma(3'd4, 6'h03, 32'h1000));
    check_val("basic_c_a_ready", bus.c_a_ready, 3'b001);
    tick();
    bus.c_a_valid = 3'b000;
    bus.m_d_valid = 1'b1;
    bus.m_d_bits  = mk_md(3'd1, 6'h03, 64'hDEAD_BEEF_0123_4567);
    bus.c_d_ready = 3'b001;
    settle();
    check_val("basic_c_d_valid", bus.c_d_valid, 3'b001);
    check_val("basic_c_d_bits", bus.c_d_bits, mk_cd(3'd1, 4'h3, 64'hDEAD_BEEF_0123_4567));
    check_val("basic_m_d_ready", bus.m_d_ready, 1'b1);
    tick();
    bus.m_d_valid = 1'b0;
    settle();
    check_val("basic_err", err_bad_source, 1'b0);

    // Round-robin: rr_ptr is 1 after the first grant, so 1,0,1,0
    set_ca(0, mk_ca(3'd4, 4'h5, 32'h100));
    set_ca(1, mk_ca(3'd4, 4'hA, 32'h200));
    bus.c_a_valid = 3'b011;
    for (int k = 0; k < 4; k++) begin
      settle();
      if (k % 2 == 0) begin
        check_val("rr_c_a_ready", bus.c_a_ready, 3'b010);
        check_val("rr_source", bus.m_a_bits[110:105], 6'h1A);
      end else begin
        check_val("rr_c_a_ready", bus.c_a_ready, 3'b001);
        check_val("rr_source", bus.m_a_bits[110:105], 6'h05);
      end
      tick();
    end
    bus.c_a_valid = 3'b000;
    bus.c_d_ready = 3'b111;
    send_d(6'h05, 3'b001);
    send_d(6'h1A, 3'b010);
    send_d(6'h05, 3'b001);
    send_d(6'h1A, 3'b010);

    // Stall hold: move rr_ptr to 2, then lock client 1 while client 0 raises valid
    bus.c_a_valid = 3'b010;
    set_ca(1, mk_ca(3'd4, 4'h2, 32'h300));
    settle();
    check_val("stall_pre_ready", bus.c_a_ready, 3'b010);
    tick();
    set_ca(1, mk_ca(3'd4, 4'h7, 32'h2000));
    bus.m_a_ready = 1'b0;
    settle();
    check_val("stall_m_a_valid", bus.m_a_valid, 1'b1);
    check_val("stall_bits_0", bus.m_a_bits, mk_ma(3'd4, 6'h17, 32'h2000));
    check_val("stall_ready_0", bus.c_a_ready, 3'b000);
    tick();
    bus.c_a_valid = 3'b011;
    set_ca(0, mk_ca(3'd4, 4'h1, 32'h400));
    for (int k = 0; k < 2; k++) begin
      settle();
      check_val("stall_bits", bus.m_a_bits, mk_ma(3'd4, 6'h17, 32'h2000));
      check_val("stall_ready", bus.c_a_ready, 3'b000);
      tick();
    end
    bus.m_a_ready = 1'b1;
    settle();
    check_val("stall_release", bus.c_a_ready, 3'b010);
    tick();
    bus.c_a_valid = 3'b001;
    settle();
    check_val("stall_next_ready", bus.c_a_ready, 3'b001);
    check_val("stall_next_bits", bus.m_a_bits, mk_ma(3'd4, 6'h01, 32'h400));
    tick();
    bus.c_a_valid = 3'b000;
    send_d(6'h12, 3'b010);
    send_d(6'h17, 3'b010);
    send_d(6'h01, 3'b001);

    // Outstanding limit on client 0
    bus.c_a_valid = 3'b001;
    for (int k = 0; k < 4; k++) begin
      set_ca(0, mk_ca(3'd0, 4'(k), 32'h500 + 32'(k*8)));
      settle();
      check_val("lim_issue", bus.c_a_ready, 3'b001);
      tick();
    end
    bus.c_a_valid = 3'b011;
    set_ca(1, mk_ca(3'd0, 4'hB, 32'h600));
    settle();
    check_val("lim_other_ready", bus.c_a_ready, 3'b010);
    check_val("lim_other_bits", bus.m_a_bits, mk_ma(3'd0, 6'h1B, 32'h600));
    tick();
    bus.c_a_valid = 3'b001;
    settle();
    check_val("lim_blocked_valid", bus.m_a_valid, 1'b0);
    check_val("lim_blocked_ready", bus.c_a_ready, 3'b000);
    bus.m_d_valid = 1'b1;
    bus.m_d_bits  = mk_md(3'd0, 6'h00, 64'd0);
    bus.c_d_ready = 3'b001;
    settle();
    check_val("lim_ack_c_d_valid", bus.c_d_valid, 3'b001);
    check_val("lim_ack_m_a_valid", bus.m_a_valid, 1'b0);
    tick();
    bus.m_d_valid = 1'b0;
    settle();
    check_val("lim_reissue", bus.c_a_ready, 3'b001);
    tick();
    bus.c_a_valid = 3'b000;

    // Bad source: prefix 3 does not exist, then client 2 with nothing outstanding
    bus.m_d_valid = 1'b1;
    bus.m_d_bits  = mk_md(3'd1, 6'h35, 64'd0);
    bus.c_d_ready = 3'b000;
    settle();
    check_val("bad_m_d_ready", bus.m_d_ready, 1'b1);
    check_val("bad_c_d_valid", bus.c_d_valid, 3'b000);
    check_val("bad_err_same", err_bad_source, 1'b0);
    tick();
    bus.m_d_valid = 1'b0;
    settle();
    check_val("bad_err_pulse", err_bad_source, 1'b1);
    tick();
    settle();
    check_val("bad_err_clear", err_bad_source, 1'b0);
    bus.m_d_valid = 1'b1;
    bus.m_d_bits  = mk_md(3'd1, 6'h20, 64'd0);
    settle();
    check_val("unexp_m_d_ready", bus.m_d_ready, 1'b1);
    check_val("unexp_c_d_valid", bus.c_d_valid, 3'b000);
    tick();
    bus.m_d_valid = 1'b0;
    settle();
    check_val("unexp_err", err_bad_source, 1'b1);

    // Reset while locked (client 0 is at its limit, client 1 gets locked)
    bus.c_a_valid = 3'b011;
    set_ca(0, mk_ca(3'd4, 4'h3, 32'h700));
    set_ca(1, mk_ca(3'd4, 4'h6, 32'h800));
    bus.m_a_ready = 1'b0;
    settle();
    check_val("rl_locked_bits", bus.m_a_bits, mk_ma(3'd4, 6'h16, 32'h800));
    tick();
    reset = 1'b1;
    settle();
    check_val("rl_m_a_valid", bus.m_a_valid, 1'b0);
    check_val("rl_c_a_ready", bus.c_a_ready, 3'b000);
    tick();
    tick();
    reset = 1'b0;
    bus.m_a_ready = 1'b1;
    settle();
    check_val("rl_first_ready", bus.c_a_ready, 3'b001);
    check_val("rl_first_bits", bus.m_a_bits, mk_ma(3'd4, 6'h03, 32'h700));
    tick();
    bus.c_a_valid = 3'b000;
    bus.m_d_valid = 1'b1;
    bus.m_d_bits  = mk_md(3'd1, 6'h16, 64'd0);
    bus.c_d_ready = 3'b111;
    settle();
    check_val("rl_stale_c_d_valid", bus.c_d_valid, 3'b000);
    check_val("rl_stale_m_d_ready", bus.m_d_ready, 1'b1);
    tick();
    bus.m_d_valid = 1'b0;
    settle();
    check_val("rl_stale_err", err_bad_source, 1'b1);

    // Same-cycle A and D on client 0 (outstanding 1) leaves the count at 1
    bus.c_a_valid = 3'b001;
    bus.m_d_valid = 1'b1;
    bus.m_d_bits  = mk_md(3'd1, 6'h03, 64'd0);
    bus.c_d_ready = 3'b001;
    settle();
    check_val("both_c_a_ready", bus.c_a_ready, 3'b001);
    check_val("both_c_d_valid", bus.c_d_valid, 3'b001);
    tick();
    bus.c_a_valid = 3'b000;
    settle();
    check_val("both_after_1", bus.c_d_valid, 3'b001);
    tick();
    settle();
    check_val("both_after_0", bus.c_d_valid, 3'b000);
    tick();
    bus.m_d_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
